// File: rtl/onehot_scan_decoder_if.sv
// Control and result bundle for onehot_scan_decoder: select/mode inputs in,
// registered one-hot, index and status outputs back.
interface onehot_scan_decoder_if #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
);
  logic             enable;
  logic             mode;
  logic [SEL_W-1:0] in;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             busy;
  logic             wrap;

  modport master (output enable, mode, in, input out, idx, busy, wrap);
  modport slave  (input enable, mode, in, output out, idx, busy, wrap);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with an optional auto-scan mode.
// The scan state, dwell counter and wrap pulse exist only when ONEHOT_SCAN_DECODER_SCAN_EN is defined.
module onehot_scan_decoder #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8,
  parameter int DWELL = 4
) (
  input logic                  clk,
  input logic                  rst,
  onehot_scan_decoder_if.slave bus
);

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
`else
  localparam int unused_dwell = DWELL;
  typedef enum logic {IDLE, DIRECT} state_t;
`endif

  state_t           state, state_next;
  logic [OUT_W-1:0] out_r, out_next;
  logic [SEL_W-1:0] idx_r, idx_next;
  logic             busy_r, busy_next;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  logic             wrap_r, wrap_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic [SEL_W-1:0] start, step;
`else
  logic             unused_mode;
`endif

  // Selects beyond OUT_W decode to all-zero rather than aliasing onto a real line.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++)
      if (int'(v) == i) r[i] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out_r  <= '0;
      idx_r  <= '0;
      busy_r <= 1'b0;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      wrap_r <= 1'b0;
      cnt_r  <= '0;
`endif
    end else begin
      state  <= state_next;
      out_r  <= out_next;
      idx_r  <= idx_next;
      busy_r <= busy_next;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      wrap_r <= wrap_next;
      cnt_r  <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next = IDLE;
    out_next   = '0;
    idx_next   = idx_r;
    busy_next  = 1'b0;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    wrap_next  = 1'b0;
    cnt_next   = '0;
    start      = (int'(bus.in) < OUT_W) ? bus.in : '0;
    step       = (int'(idx_r) == OUT_W - 1) ? '0 : idx_r + 1'b1;
`endif
    if (bus.enable) begin
      busy_next = 1'b1;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
      if (bus.mode) begin
        state_next = SCAN;
        // Entering from IDLE or DIRECT restarts the sweep at the requested position.
        if (state != SCAN) begin
          idx_next = start;
          out_next = onehot(start);
        end else if (int'(cnt_r) == DWELL - 1) begin
          idx_next  = step;
          out_next  = onehot(step);
          wrap_next = (int'(idx_r) == OUT_W - 1);
        end else begin
          cnt_next = cnt_r + 1'b1;
          out_next = out_r;
        end
      end else
`endif
      begin
        state_next = DIRECT;
        idx_next   = bus.in;
        out_next   = onehot(bus.in);
      end
    end
  end

  assign bus.out  = out_r;
  assign bus.idx  = idx_r;
  assign bus.busy = busy_r;
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
  assign bus.wrap = wrap_r;
`else
  assign bus.wrap    = 1'b0;
  assign unused_mode = bus.mode;
`endif

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: default, OUT_W=5 and DWELL=1 instances.
// Scan checks run when ONEHOT_SCAN_DECODER_SCAN_EN is defined, otherwise the scan-disabled checks do.
module tb_onehot_scan_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  typedef struct {
    logic       en;
    logic       md;
    logic [2:0] sel;
    logic [7:0] exp_out;
    logic [2:0] exp_idx;
    logic       exp_busy;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[9];

  onehot_scan_decoder_if #(.SEL_W(3), .OUT_W(8)) if_a ();
  onehot_scan_decoder_if #(.SEL_W(3), .OUT_W(5)) if_b ();
  onehot_scan_decoder_if #(.SEL_W(3), .OUT_W(8)) if_c ();

  onehot_scan_decoder #(.SEL_W(3), .OUT_W(8), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  onehot_scan_decoder #(.SEL_W(3), .OUT_W(5), .DWELL(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  onehot_scan_decoder #(.SEL_W(3), .OUT_W(8), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int unit, input logic en, input logic md, input logic [2:0] sel);
    case (unit)
      0: begin if_a.enable = en; if_a.mode = md; if_a.in = sel; end
      1: begin if_b.enable = en; if_b.mode = md; if_b.in = sel; end
      default: begin if_c.enable = en; if_c.mode = md; if_c.in = sel; end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    int first_wrap;
    int second_wrap;
    int wrap_count;
    logic [7:0] exp_out;
`endif
    logic start_mode;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 3'(i), 8'(1 << i), 3'(i), 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 1'b0, 1'b0};

    applyStimulus(0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1, 1'b0, 1'b0, 3'd0);
    applyStimulus(2, 1'b0, 1'b0, 3'd0);

    #1 rst = 1'b1;
    #2;
    checkOutput("reset_out", if_a.out, 8'h00);
    checkOutput("reset_idx", if_a.idx, 3'd0);
    checkOutput("reset_busy", if_a.busy, 1'b0);
    checkOutput("reset_wrap", if_a.wrap, 1'b0);
    #9 rst = 1'b0;

    $display("[TB] direct sweep");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, vecs[i].en, vecs[i].md, vecs[i].sel);
      tick();
      checkOutput("direct_out", if_a.out, vecs[i].exp_out);
      checkOutput("direct_idx", if_a.idx, vecs[i].exp_idx);
      checkOutput("direct_busy", if_a.busy, vecs[i].exp_busy);
      checkOutput("direct_wrap", if_a.wrap, vecs[i].exp_wrap);
    end

    $display("[TB] out-of-range select, OUT_W=5");
    applyStimulus(1, 1'b1, 1'b0, 3'd6);
    tick();
    checkOutput("oor_direct_out", if_b.out, 5'b00000);
    checkOutput("oor_direct_busy", if_b.busy, 1'b1);
    checkOutput("oor_direct_idx", if_b.idx, 3'd6);
    applyStimulus(1, 1'b1, 1'b1, 3'd6);
    tick();
`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    checkOutput("oor_scan_out", if_b.out, 5'b00001);
    checkOutput("oor_scan_idx", if_b.idx, 3'd0);
`else
    checkOutput("oor_mode_ignored_out", if_b.out, 5'b00000);
`endif
    checkOutput("oor_scan_busy", if_b.busy, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 3'd0);

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    $display("[TB] scan sweep from 6, DWELL=4");
    applyStimulus(0, 1'b1, 1'b1, 3'd6);
    first_wrap  = -1;
    second_wrap = -1;
    wrap_count  = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 1) applyStimulus(0, 1'b1, 1'b1, 3'd2);
      if (k <= 12) begin
        exp_out = (k <= 4) ? 8'h40 : (k <= 8) ? 8'h80 : 8'h01;
        checkOutput("scan_out", if_a.out, exp_out);
        checkOutput("scan_wrap", if_a.wrap, (k == 9) ? 1'b1 : 1'b0);
        checkOutput("scan_busy", if_a.busy, 1'b1);
      end
      if (if_a.wrap) begin
        wrap_count++;
        if (first_wrap < 0) first_wrap = k;
        else if (second_wrap < 0) second_wrap = k;
      end
    end
    checkOutput("first_wrap_cycle", first_wrap, 9);
    checkOutput("wrap_interval", second_wrap - first_wrap, 32);
    checkOutput("wrap_count", wrap_count, 2);
    applyStimulus(0, 1'b0, 1'b0, 3'd0);
    tick();
    start_mode = 1'b1;
`else
    start_mode = 1'b0;
`endif

    $display("[TB] async reset while active at idx 5");
    applyStimulus(0, 1'b1, start_mode, 3'd5);
    tick();
    checkOutput("pre_reset_idx", if_a.idx, 3'd5);
    checkOutput("pre_reset_out", if_a.out, 8'h20);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_out", if_a.out, 8'h00);
    checkOutput("async_reset_idx", if_a.idx, 3'd0);
    checkOutput("async_reset_busy", if_a.busy, 1'b0);
    checkOutput("async_reset_wrap", if_a.wrap, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 3'd0);
    #3 rst = 1'b0;
    tick();
    checkOutput("idle_out", if_a.out, 8'h00);
    checkOutput("idle_busy", if_a.busy, 1'b0);

`ifdef ONEHOT_SCAN_DECODER_SCAN_EN
    $display("[TB] DWELL=1 scan and mode switching");
    applyStimulus(2, 1'b1, 1'b1, 3'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("dwell1_idx", if_c.idx, 3'((k - 1) % 8));
      checkOutput("dwell1_wrap", if_c.wrap, (k == 9) ? 1'b1 : 1'b0);
    end
    applyStimulus(2, 1'b1, 1'b0, 3'd2);
    tick();
    checkOutput("switch_direct_out", if_c.out, 8'h04);
    checkOutput("switch_direct_wrap", if_c.wrap, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 3'd7);
    tick();
    checkOutput("reentry_out", if_c.out, 8'h80);
    checkOutput("reentry_wrap", if_c.wrap, 1'b0);
    tick();
    checkOutput("reentry_next_out", if_c.out, 8'h01);
    checkOutput("reentry_next_wrap", if_c.wrap, 1'b1);
`else
    $display("[TB] scan disabled: mode=1 behaves as direct");
    applyStimulus(0, 1'b1, 1'b1, 3'd3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("noscan_out", if_a.out, 8'h08);
      checkOutput("noscan_wrap", if_a.wrap, 1'b0);
    end
    applyStimulus(2, 1'b1, 1'b1, 3'd7);
    tick();
    checkOutput("noscan_dwell1_out", if_c.out, 8'h80);
    tick();
    checkOutput("noscan_dwell1_hold", if_c.out, 8'h80);
    checkOutput("noscan_dwell1_wrap", if_c.wrap, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder with an added auto-scan mode. In direct mode it decodes `in` to a one-hot `out` with one cycle of latency. In scan mode it steps a one-hot pattern through all outputs, holding each position for a programmable dwell time. It drives row/column select lines, LED scanners and demux enables in the lab designs. It is the clocked, generalised successor to the 3-to-8 combinational decoder.

## Interface
Parameters:
- `SEL_W`, default 3: select width. Legal range is at least 1.
- `OUT_W`, default 8: number of one-hot outputs. Legal range is 2 to 2**SEL_W.
- `DWELL`, default 4: clock cycles each position is held in scan mode. Legal range is at least 1.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `enable`  input  1  1 = decoder active; 0 = outputs cleared.
- `mode`  input  1  0 = direct decode; 1 = auto-scan.
- `in`  input  SEL_W  select value in direct mode; start position on scan entry.
- `out`  output  OUT_W  registered one-hot output (all-zero when idle or out of range).
- `idx`  output  SEL_W  registered index currently decoded onto `out`.
- `busy`  output  1  registered; 1 when state is DIRECT or SCAN.
- `wrap`  output  1  registered one-cycle pulse when scan index wraps from OUT_W-1 to 0.

## Operation
- State machine has three states:
  - IDLE.
  - DIRECT.
  - SCAN.
- State is re-evaluated every cycle from `enable`/`mode`.
- Internal dwell counter `cnt` is $clog2(DWELL) bits wide, minimum 1.
- `onehot(v)` is `1 << v` when v < OUT_W, otherwise all-zero.
- `enable`=0, from any state:
  - Next state IDLE.
  - `out` <= 0, `cnt` <= 0, `wrap` <= 0, `busy` <= 0.
  - `idx` holds its value.
- `enable`=1, `mode`=0:
  - Next state DIRECT.
  - `out` <= onehot(`in`), `idx` <= `in`, `cnt` <= 0, `wrap` <= 0.
  - An out-of-range `in` gives `out`=0 with `busy`=1.
- `enable`=1, `mode`=1, current state not SCAN (scan entry):
  - Next state SCAN.
  - Start position s = `in` if `in` < OUT_W, else 0.
  - `idx` <= s, `out` <= onehot(s), `cnt` <= 0, `wrap` <= 0.
- `enable`=1, `mode`=1, current state SCAN:
  - If `cnt` == DWELL-1:
    - `cnt` <= 0.
    - `idx` <= (`idx` == OUT_W-1) ? 0 : `idx`+1.
    - `out` <= onehot(new idx).
    - `wrap` <= 1 only on the OUT_W-1 -> 0 step.
  - Otherwise: `cnt` <= `cnt`+1, `out`/`idx` hold, `wrap` <= 0.
- In SCAN, `in` is ignored after entry.
- Switching `mode` 1->0 takes effect on the next edge, as DIRECT.
- Switching `mode` 0->1 is a fresh scan entry from the current `in`.
- `out` is always either all-zero or exactly one bit set; never multi-hot.

## Timing
- Reset values, asynchronous on `rst`=1:
  - `out`=0, `idx`=0, `busy`=0, `wrap`=0.
  - `cnt`=0, state IDLE.
- Reset asserted mid-scan clears everything immediately.
- After `rst` deasserts, the first rising edge evaluates the inputs normally.
- Latency:
  - Direct mode: `in` change is visible on `out` one edge later.
  - `enable` fall: `out`=0 one edge later.
- Scan entry: the start position appears one edge after `mode`/`enable` rise. It is held DWELL edges in total, including the entry edge.
- Each subsequent position is held exactly DWELL cycles. A full sweep is OUT_W*DWELL cycles.
- DWELL=1: index advances every cycle; `wrap` pulses once every OUT_W cycles.
- `wrap` is high for exactly one cycle, coincident with `idx`=0 / `out`[0]=1 after the wrap.

## Configuration
- Macro `ONEHOT_SCAN_DECODER_SCAN_EN`.
- Defined: full behaviour as above.
- Not defined:
  - SCAN state and dwell counter are compiled out.
  - `mode` is ignored and treated as 0, so `enable`=1 always means DIRECT.
  - `wrap` is tied to 0.
  - All other behaviour and reset values are unchanged.

## Test plan
All scenarios use defaults (SEL_W=3, OUT_W=8, DWELL=4) unless noted.
- Reset/idle:
  - Stimulus: `rst`=1 mid-scan at idx=5.
  - Required: out=0, idx=0, busy=0, wrap=0 immediately, without waiting for an edge.
  - Stimulus: `enable`=0 afterwards.
  - Required: out stays 0.
- Direct sweep:
  - Stimulus: `enable`=1, `mode`=0, `in`=0..7, one value per cycle.
  - Required: one cycle later, out = 8'h01, 02, 04, ..., 80; idx tracks in; busy=1.
  - Stimulus: drop `enable`.
  - Required: out=0 next cycle.
- Out-of-range:
  - Stimulus: OUT_W=5, `in`=6 in direct mode.
  - Required: out=0, busy=1.
  - Stimulus: scan entry with `in`=6.
  - Required: scan starts at idx=0, out=5'b00001.
- Scan sweep:
  - Stimulus: `mode`=1, `enable`=1, `in`=6.
  - Required sequence:
    - out=8'h40 for 4 cycles.
    - 8'h80 for 4 cycles.
    - 8'h01 for 4 cycles, with `wrap`=1 only on the first of those.
  - Required: the next wrap pulse comes 32 cycles later.
- Mode switch and dwell edge:
  - Stimulus: DWELL=1, scanning; set `mode`=0 with `in`=2.
  - Required: next cycle out=8'h04, no wrap.
  - Stimulus: set `mode`=1 with `in`=7.
  - Required: out=8'h80, then 8'h01 with wrap=1 on the following cycle.
- Macro off:
  - Stimulus: build without `ONEHOT_SCAN_DECODER_SCAN_EN`, drive `mode`=1 with `in`=3.
  - Required: out=8'h08 constant; wrap never asserts.
